// File: rtl/seg_pkg.sv
// Shared constants, glyphs and FSM state type for the shared 7-segment display arbiter.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_W      = 7;
  localparam int unsigned PAT_W      = NUM_DIGITS * DIG_W;

  localparam logic [3:0] AN_D0    = 4'b0111;
  localparam logic [3:0] AN_D1    = 4'b1011;
  localparam logic [3:0] AN_D2    = 4'b1101;
  localparam logic [3:0] AN_D3    = 4'b1110;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  localparam logic [DIG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [DIG_W-1:0] GLYPH_S   = 7'b0010010;
  localparam logic [DIG_W-1:0] GLYPH_A   = 7'b0001000;
  localparam logic [DIG_W-1:0] GLYPH_F   = 7'b0001110;
  localparam logic [DIG_W-1:0] GLYPH_E   = 7'b0000110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  function automatic logic [3:0] anode_code(input logic [1:0] idx);
    logic [3:0] code;
    code = AN_BLANK;
    case (idx)
      2'd0: code = AN_D0;
      2'd1: code = AN_D1;
      2'd2: code = AN_D2;
      2'd3: code = AN_D3;
      default: code = AN_BLANK;
    endcase
    return code;
  endfunction

  // Digit 0 is the leftmost glyph, stored in the top bits of the pattern.
  function automatic logic [DIG_W-1:0] digit_glyph(input logic [PAT_W-1:0] pat,
                                                   input logic [1:0]       idx);
    logic [DIG_W-1:0] glyph;
    glyph = SEG_BLANK;
    case (idx)
      2'd0: glyph = pat[27:21];
      2'd1: glyph = pat[20:14];
      2'd2: glyph = pat[13:7];
      2'd3: glyph = pat[6:0];
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_scan_tick.sv
// Free-running scan divider: pulses tick for one cycle every SCAN_DIV clocks.
module seg_scan_tick #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration of the 4-digit display with minimum hold time,
// plus the anode/segment scan for the current owner.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned HOLD_TICKS = 400
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [PAT_W-1:0] pat0,
  input  logic [PAT_W-1:0] pat1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [3:0]       an,
  output logic [DIG_W-1:0] seg
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [3:0]        an_q, an_d;
  logic [DIG_W-1:0]  seg_q, seg_d;
  logic [PAT_W-1:0]  owner_pat;
  logic              hold_done;
  logic              tick;

  seg_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    an_d      = an_q;
    seg_d     = seg_q;
    hold_done = (hold_q >= HOLD_W'(HOLD_TICKS));
    owner_pat = (state_q == ST_OWN1) ? pat1 : pat0;

    case (state_q)
      ST_IDLE: begin
        if (req == 2'b11)  state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (req[0])   state_d = ST_OWN0;
        else if (req[1])   state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req[0])                state_d = req[1] ? ST_OWN1 : ST_IDLE;
        else if (hold_done && req[1]) state_d = ST_OWN1;
      end
      ST_OWN1: begin
        if (!req[1])                state_d = req[0] ? ST_OWN0 : ST_IDLE;
        else if (hold_done && req[0]) state_d = ST_OWN0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A grant change blanks the display so the old owner's glyph never ghosts.
    if (state_d != state_q) begin
      if (state_d == ST_OWN0)      last_d = 1'b0;
      else if (state_d == ST_OWN1) last_d = 1'b1;
      hold_d = '0;
      idx_d  = '0;
      an_d   = AN_BLANK;
      seg_d  = SEG_BLANK;
    end else if (tick) begin
      if (state_q == ST_IDLE) begin
        an_d  = AN_BLANK;
        seg_d = SEG_BLANK;
      end else begin
        an_d  = anode_code(idx_q);
        seg_d = digit_glyph(owner_pat, idx_q);
        idx_d = idx_q + 2'd1;
        if (!hold_done) hold_d = hold_q + HOLD_W'(1);
      end
    end

    gnt_d  = {state_d == ST_OWN1, state_d == ST_OWN0};
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
      hold_q  <= '0;
      idx_q   <= '0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      an_q    <= AN_BLANK;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed testbench for seg_display_arbiter with SCAN_DIV=4, HOLD_TICKS=3.
module tb_seg_display_arbiter;

  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned HOLD_TICKS = 3;

  localparam logic [6:0] G_S = 7'b0010010;
  localparam logic [6:0] G_A = 7'b0001000;
  localparam logic [6:0] G_F = 7'b0001110;
  localparam logic [6:0] G_E = 7'b0000110;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req   = 2'b00;
  logic [27:0] pat0  = '0;
  logic [27:0] pat1  = '0;
  logic [1:0]  gnt;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  seg_display_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .pat0  (pat0),
    .pat1  (pat1),
    .gnt   (gnt),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  always #5 clock = ~clock;

  // Reference scan divider: tb_tick high means the coming rising edge is a tick edge.
  logic [1:0] tb_cnt = 2'd0;
  logic       tb_tick;
  always @(posedge clock) tb_cnt <= (reset || tb_cnt == 2'(SCAN_DIV - 1)) ? 2'd0 : tb_cnt + 2'd1;
  assign tb_tick = (tb_cnt == 2'(SCAN_DIV - 1));

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] v;
    v = 4'b1111;
    v[3-k] = 1'b0;
    return v;
  endfunction

  function automatic logic [6:0] dig(input logic [27:0] p, input int k);
    return 7'(p >> (7 * (3 - k)));
  endfunction

  // Ends at the negedge after the last reset edge, with req applied throughout.
  task automatic do_reset(input logic [1:0] r);
    @(negedge clock);
    reset = 1'b1;
    req   = r;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Called just after a rising edge; returns #1 after the next tick edge.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clock);
    while (!tb_tick && n < 2 * SCAN_DIV) begin
      @(negedge clock);
      n++;
    end
    if (!tb_tick) begin
      $display("FAIL wait_tick: no scan tick within %0d cycles", 2 * SCAN_DIV);
      $fatal(1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = 2'b00;
    repeat (3) begin
      @(posedge clock); #1;
      total++;
      if ({gnt, busy, an, seg} !== {2'b00, 1'b0, 4'b1111, 7'b1111111}) begin
        bad++;
        $display("FAIL reset_held: got gnt=%b busy=%b an=%b seg=%b want 00/0/1111/1111111", gnt, busy, an, seg);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      total++;
      if ({gnt, busy, an, seg} !== {2'b00, 1'b0, 4'b1111, 7'b1111111}) begin
        bad++;
        $display("FAIL reset_idle: got gnt=%b busy=%b an=%b seg=%b want 00/0/1111/1111111", gnt, busy, an, seg);
      end
    end
  endtask

  task automatic test_single_scan();
    pat0 = {G_S, G_A, G_F, G_E};
    do_reset(2'b00);
    req = 2'b01;
    @(posedge clock); #1;
    total++;
    if ({gnt, busy, an, seg} !== {2'b01, 1'b1, 4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b busy=%b an=%b seg=%b want 01/1/1111/1111111", gnt, busy, an, seg);
    end
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      total++;
      if ({gnt, an, seg} !== {2'b01, an_of(i % 4), dig(pat0, i % 4)}) begin
        bad++;
        $display("FAIL single_scan[%0d]: got gnt=%b an=%b seg=%b want 01/%b/%b", i, gnt, an, seg, an_of(i % 4), dig(pat0, i % 4));
      end
    end
    @(negedge clock);
    req = 2'b00;
    @(posedge clock); #1;
    total++;
    if ({gnt, busy, an, seg} !== {2'b00, 1'b0, 4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL single_release: got gnt=%b busy=%b an=%b seg=%b want 00/0/1111/1111111", gnt, busy, an, seg);
    end
    wait_tick();
    total++;
    if ({an, seg} !== {4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL single_idle_tick: got an=%b seg=%b want 1111/1111111", an, seg);
    end
  endtask

  task automatic test_round_robin();
    pat0 = {G_S, G_A, G_F, G_E};
    pat1 = {G_E, G_F, G_A, G_S};
    do_reset(2'b11);
    @(posedge clock); #1;
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL rr_first_contest: got gnt=%b want 10", gnt);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      total++;
      if ({gnt, an, seg} !== {2'b10, an_of(i), dig(pat1, i)}) begin
        bad++;
        $display("FAIL rr_own1_tick[%0d]: got gnt=%b an=%b seg=%b want 10/%b/%b", i, gnt, an, seg, an_of(i), dig(pat1, i));
      end
    end
    @(posedge clock); #1;
    total++;
    if ({gnt, an, seg} !== {2'b01, 4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL rr_switch_blank: got gnt=%b an=%b seg=%b want 01/1111/1111111", gnt, an, seg);
    end
    @(posedge clock); #1;
    total++;
    if ({an, seg} !== {4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL rr_blank_hold: got an=%b seg=%b want 1111/1111111", an, seg);
    end
    wait_tick();
    total++;
    if ({gnt, an, seg} !== {2'b01, 4'b0111, G_S}) begin
      bad++;
      $display("FAIL rr_own0_digit0: got gnt=%b an=%b seg=%b want 01/0111/%b", gnt, an, seg, G_S);
    end
    wait_tick();
    wait_tick();
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL rr_own0_held: got gnt=%b want 01", gnt);
    end
    @(posedge clock); #1;
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL rr_switch_back: got gnt=%b want 10", gnt);
    end
  endtask

  task automatic test_drop();
    do_reset(2'b11);
    @(posedge clock); #1;
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL drop_own1: got gnt=%b want 10", gnt);
    end
    wait_tick();
    @(negedge clock);
    req = 2'b01;
    @(posedge clock); #1;
    total++;
    if ({gnt, an, seg} !== {2'b01, 4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL drop_no_hold: got gnt=%b an=%b seg=%b want 01/1111/1111111", gnt, an, seg);
    end
    @(negedge clock);
    req = 2'b10;
    @(posedge clock); #1;
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL drop_swap: got gnt=%b want 10", gnt);
    end
    @(negedge clock);
    req = 2'b00;
    @(posedge clock); #1;
    total++;
    if ({gnt, busy} !== {2'b00, 1'b0}) begin
      bad++;
      $display("FAIL drop_both: got gnt=%b busy=%b want 00/0", gnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    pat0 = {G_S, G_A, G_F, G_E};
    do_reset(2'b01);
    @(posedge clock); #1;
    wait_tick();
    wait_tick();
    total++;
    if ({gnt, an, seg} !== {2'b01, 4'b1011, G_A}) begin
      bad++;
      $display("FAIL midrst_pre: got gnt=%b an=%b seg=%b want 01/1011/%b", gnt, an, seg, G_A);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if ({gnt, busy, an, seg} !== {2'b00, 1'b0, 4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL midrst_outputs: got gnt=%b busy=%b an=%b seg=%b want 00/0/1111/1111111", gnt, busy, an, seg);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL midrst_regrant: got gnt=%b want 01", gnt);
    end
    wait_tick();
    total++;
    if ({an, seg} !== {4'b0111, G_S}) begin
      bad++;
      $display("FAIL midrst_digit0: got an=%b seg=%b want 0111/%b", an, seg, G_S);
    end
  endtask

  task automatic test_pattern_sample();
    logic [27:0] pa;
    logic [27:0] pb;
    pa = {G_A, G_F, G_E, G_S};
    pb = {G_E, G_S, G_A, G_F};
    pat0 = pa;
    do_reset(2'b01);
    @(posedge clock); #1;
    @(negedge clock);
    for (int n = 0; n < 2 * SCAN_DIV && !tb_tick; n++) @(negedge clock);
    pat0 = pb;
    @(posedge clock); #1;
    total++;
    if ({an, seg} !== {4'b0111, dig(pb, 0)}) begin
      bad++;
      $display("FAIL pat_at_tick: got an=%b seg=%b want 0111/%b", an, seg, dig(pb, 0));
    end
    pat0 = pa;
    @(posedge clock); #1;
    total++;
    if (seg !== dig(pb, 0)) begin
      bad++;
      $display("FAIL pat_between_ticks: got seg=%b want %b", seg, dig(pb, 0));
    end
    wait_tick();
    total++;
    if ({an, seg} !== {4'b1011, dig(pa, 1)}) begin
      bad++;
      $display("FAIL pat_live_next: got an=%b seg=%b want 1011/%b", an, seg, dig(pa, 1));
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_pattern_sample();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single 4-digit, 7-segment display between two pattern sources, e.g. the "SAFE" message generator and a numeric readout. It grants ownership with a request/grant handshake and enforces a minimum hold time with round-robin fairness. It also drives the persistence-of-vision digit scan (anode multiplexing) for whichever source owns the display. It sits between the pattern producers and the top-level `an`/`seg` pins.

## Interface
- `SCAN_DIV`, 100000: clock cycles per scan tick (one digit slot); minimum 2.
- `HOLD_TICKS`, 400: minimum ownership length in scan ticks before a competing request can preempt; minimum 1.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  2  per-source request; held high while the source wants the display.
- `pat0`  in  28  source 0 glyphs: [27:21] digit 0 (leftmost) … [6:0] digit 3; active-low segments.
- `pat1`  in  28  source 1 glyphs, same layout.
- `gnt`  out  2  one-hot grant, or 2'b00 when idle; registered.
- `busy`  out  1  high whenever `gnt != 0`.
- `an`  out  4  active-low anodes; digit k is driven by clearing bit 3-k (digit 0 → 4'b0111).
- `seg`  out  7  active-low segments of the currently scanned digit.

## Operation
- Reset values: `gnt`=2'b00, `busy`=0, `an`=4'b1111, `seg`=7'b1111111. Scan counter, digit index, hold counter and last-served all reset to 0.
- Scan tick: a free-running counter runs 0..SCAN_DIV-1. `tick` is high for the one cycle where count==SCAN_DIV-1.
- FSM states:
  - IDLE: display blank.
    - Any `req` bit set → grant. If both are set, grant the source that is not last-served. Reset leaves last-served=0, so source 1 wins the first contest.
  - OWN0 / OWN1:
    - Owner drops `req` → go to the other source if it is requesting, else IDLE.
    - Owner still requesting, hold counter ≥ HOLD_TICKS and the other source requesting → switch to the other source.
    - Otherwise stay.
- Every grant change loads the new owner into last-served, clears the hold counter and resets the digit index to 0.
- Hold counter increments on each `tick` while owned and saturates at HOLD_TICKS.
- Display, on each `tick`:
  - Owned: `an` ← anode code of the current digit index, `seg` ← that digit's 7 bits, sampled live from the owner's pattern. Then the index advances 0→1→2→3→0.
  - IDLE: `an`=4'b1111, `seg`=7'b1111111.
- Grant-change blanking: `an`=4'b1111 and `seg`=7'b1111111 from the cycle after the grant change until the next `tick`. This prevents ghosting of the old owner's glyph.
- Both requests dropping in the same cycle → IDLE. A simultaneous drop by the owner and rise by the other source → switch.

## Timing
- `req` sampled high in IDLE at edge N → `gnt`/`busy` valid after edge N+1.
- Owner `req` low at edge N → `gnt` changes after edge N+1.
- `an`/`seg` change only on `tick` edges, plus the blanking write on a grant change.
- First digit of a new owner appears at the first `tick` after the grant; worst case SCAN_DIV cycles later.
- Pattern inputs need to be stable only at `tick` edges.
- Reset asserted mid-scan: all outputs take their reset values at the next edge, and the scan restarts from count 0.

## Structure
- Package `seg_pkg`:
  - anode codes (4'b0111, 4'b1011, 4'b1101, 4'b1110, blank 4'b1111);
  - blank segment code 7'b1111111;
  - glyph constants S=7'b0010010, A=7'b0001000, F=7'b0001110, E=7'b0000110;
  - FSM state enum.
- Sub-module `seg_scan_tick` (parameter SCAN_DIV; ports `clock`, `reset`, `tick`) holds the divider. The FSM, hold counter and digit mux live in the top module.

## Test plan
Bench parameters: SCAN_DIV=4, HOLD_TICKS=3.
- Reset with both `req`=0 → `gnt`=00, `an`=1111, `seg`=1111111 held for 40 cycles.
- `req`=01, `pat0`={S,A,F,E} → `gnt`=01 one cycle later. Consecutive ticks give `an`/`seg` = 0111/0010010, 1011/0001000, 1101/0001110, 1110/0000110, then repeat.
- `req`=11 from reset → `gnt`=10. Keep both requesting → `gnt` flips to 01 on the cycle after the 3rd owned tick, blanks until the next tick, then shows digit 0 of `pat0`.
- Source 1 owns and drops `req` after 1 tick while `req[0]`=1 → `gnt`=01 one cycle later, with no hold wait.
- `reset` pulsed mid-scan while owned → next edge `gnt`=00, `an`=1111, `seg`=1111111. Re-grant restarts at digit 0.
- Pattern changed between ticks → `seg` reflects only the value present at the tick edge.
